ws2812b_frame_sequencer: RTL and testbench
==========================================

# ws2812b_frame_sequencer

Frame sequencer between the rotary-encoder controller and the WS2812B bit-timing driver. On each refresh request it snapshots the 12-bit LED mask and the intensity byte. It then streams one full frame of GRB colour bits to the bit driver over a valid/ready handshake, and enforces the WS2812B latch (reset) low period before reporting completion. Refresh requests that arrive while a frame is in flight are merged into one pending frame.

## Interface
- NUM_LEDS, 12, LEDs in the ring; frame length is NUM_LEDS×24 bits
- LATCH_CYCLES, 2000, clk cycles of idle line after the last bit (50 µs at 40 MHz); must be ≥1
- ON_CHANNELS, 3'b010, {G,R,B} enables; an enabled channel of a lit LED carries the intensity byte, a disabled channel carries 0x00
- clk  in  1  system clock (40 MHz)
- res_n  in  1  reset, asynchronous, active-low
- refresh  in  1  frame request, sampled each cycle, level or pulse
- led_mask  in  NUM_LEDS  bit i set = LED i lit
- intensity  in  8  brightness byte for enabled channels of lit LEDs
- bit_valid  out  1  bit_data holds a bit for the driver
- bit_data  out  1  current colour bit
- bit_ready  in  1  driver accepts bit_data this cycle
- busy  out  1  frame in SEND or LATCH
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, SEND, LATCH.
- IDLE: if refresh=1, capture led_mask and intensity into shadow registers, clear the LED index and bit index, and go to SEND.
- SEND: bit_valid=1. A transfer occurs when bit_valid and bit_ready are both 1.
  - Order: LED 0 first. Within each LED: G, then R, then B byte, each MSB first.
  - bit_data = shadow_mask[led] & ON_CHANNELS[ch] & intensity_shadow[7-bit].
  - Bit index counts 0..23 and wraps to 0 as the LED index increments.
  - After the transfer of LED NUM_LEDS-1, bit 23, go to LATCH.
- LATCH: bit_valid=0 and bit_data=0. The latch counter runs LATCH_CYCLES cycles, then:
  - frame_done=1 for one cycle.
  - If pending=1: clear pending, re-capture led_mask and intensity, and enter SEND.
  - Otherwise: enter IDLE.
- pending: set by refresh=1 sampled in any SEND or LATCH cycle, including the final LATCH cycle. Any number of such requests collapse into one frame.
- bit_data must stay constant while bit_valid=1 and bit_ready=0. bit_ready is ignored while bit_valid=0.
- Shadow registers are frozen during a frame. Input changes take effect only at the next capture.
- Widths:
  - LED index: $clog2(NUM_LEDS).
  - Bit index: 5 bits.
  - Latch counter: $clog2(LATCH_CYCLES+1).
  - No counter may overflow at any parameter value.
- Reset (res_n=0, any time, including mid-frame): state=IDLE; bit_valid=0, bit_data=0, busy=0, frame_done=0; pending, counters and shadow registers cleared. A partially sent frame is abandoned, never resumed.

## Timing
- All outputs are registered.
- Refresh sampled high in IDLE at edge k: bit_valid=1 and busy=1 from cycle k+1, with LED 0 G bit 7 on bit_data.
- With bit_ready held at 1: one bit per cycle, so a frame is NUM_LEDS×24 consecutive cycles.
- Last transfer at cycle T:
  - bit_valid=0 during cycles T+1 … T+LATCH_CYCLES.
  - frame_done=1 in cycle T+LATCH_CYCLES+1.
  - busy=0 in that same cycle, unless pending.
  - If pending: bit_valid=1 in cycle T+LATCH_CYCLES+1, and busy stays 1.
- Minimum frame period with no backpressure: NUM_LEDS×24 + LATCH_CYCLES + 1 cycles (2289 at defaults).
- Refresh high in the frame_done cycle while IDLE is captured normally, giving a start at the next cycle.

## Test plan
- Reset, then refresh pulse with led_mask=0x001, intensity=0x20, bit_ready=1. Required response:
  - 288 transfers: 0x00, 0x20, 0x00, followed by 264 zero bits.
  - bit_valid low for exactly 2000 cycles, then frame_done for one cycle; busy low afterwards.
- led_mask=0xFFF, intensity=0x01, ON_CHANNELS=3'b111: every LED sends 0x01 0x01 0x01, so a 1 appears at bit positions 7, 15, 23 of each 24-bit group.
- Random bit_ready backpressure, led_mask=0x5A5, intensity=0x08: bit_data is stable whenever valid and not ready, and the received stream matches the no-backpressure reference bit-for-bit.
- Three refresh pulses during SEND, with led_mask changed to 0x800 during LATCH: exactly two frames are sent; the second frame starts in the frame_done cycle and carries the LED 11 pattern.
- res_n pulsed low at transfer 100: bit_valid=0 and busy=0 immediately; no frame_done. A later refresh produces a complete fresh frame starting from LED 0 G bit 7.
- led_mask and intensity toggled every cycle during SEND: the emitted frame equals the values captured at start.

Source files
------------

// File: rtl/ws2812b_frame_sequencer.sv
// Streams one GRB frame per refresh to a WS2812B bit driver over valid/ready,
// then holds the line idle for the latch period before pulsing frame_done.
module ws2812b_frame_sequencer #(
   parameter int         NUM_LEDS     = 12,
   parameter int         LATCH_CYCLES = 2000,
   parameter logic [2:0] ON_CHANNELS  = 3'b010
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic                refresh,
   input  logic [NUM_LEDS-1:0] led_mask,
   input  logic [7:0]          intensity,
   output logic                bit_valid,
   output logic                bit_data,
   input  logic                bit_ready,
   output logic                busy,
   output logic                frame_done
);
   localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
   localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

   state_t              state, state_n;
   logic [LED_W-1:0]    led_idx, led_idx_n, nxt_led;
   logic [4:0]          bit_idx, bit_idx_n, nxt_bit;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [NUM_LEDS-1:0] mask_sh, mask_sh_n;
   logic [7:0]          int_sh, int_sh_n;
   logic                pending, pending_n;
   logic                valid_n, data_n, busy_n, done_n, last_bit;

   // Bit b of an LED: byte b/8 selects G,R,B; bits go out MSB first.
   function automatic logic color_bit(input logic [NUM_LEDS-1:0] m, input logic [7:0] in,
                                      input logic [LED_W-1:0] led, input logic [4:0] b);
      logic on;
      case (b[4:3])
         2'd0:    on = ON_CHANNELS[2];
         2'd1:    on = ON_CHANNELS[1];
         default: on = ON_CHANNELS[0];
      endcase
      return m[led] & on & in[~b[2:0]];
   endfunction

   assign last_bit = (bit_idx == 5'd23);
   assign nxt_bit  = last_bit ? 5'd0 : bit_idx + 5'd1;
   assign nxt_led  = last_bit ? led_idx + LED_W'(1) : led_idx;

   always_comb begin
      state_n   = state;
      led_idx_n = led_idx;
      bit_idx_n = bit_idx;
      cnt_n     = cnt;
      mask_sh_n = mask_sh;
      int_sh_n  = int_sh;
      pending_n = pending;
      valid_n   = bit_valid;
      data_n    = bit_data;
      busy_n    = busy;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (refresh) begin
               state_n   = SEND;
               mask_sh_n = led_mask;
               int_sh_n  = intensity;
               led_idx_n = '0;
               bit_idx_n = '0;
               valid_n   = 1'b1;
               data_n    = color_bit(led_mask, intensity, '0, '0);
               busy_n    = 1'b1;
            end
         end
         SEND: begin
            if (refresh) pending_n = 1'b1;
            if (bit_ready) begin
               if (last_bit && led_idx == LAST_LED) begin
                  state_n = LATCH;
                  valid_n = 1'b0;
                  data_n  = 1'b0;
                  cnt_n   = '0;
               end else begin
                  led_idx_n = nxt_led;
                  bit_idx_n = nxt_bit;
                  data_n    = color_bit(mask_sh, int_sh, nxt_led, nxt_bit);
               end
            end
         end
         LATCH: begin
            if (cnt == LAST_CNT) begin
               done_n = 1'b1;
               // A request seen in this very cycle still counts as pending.
               if (pending || refresh) begin
                  state_n   = SEND;
                  pending_n = 1'b0;
                  mask_sh_n = led_mask;
                  int_sh_n  = intensity;
                  led_idx_n = '0;
                  bit_idx_n = '0;
                  valid_n   = 1'b1;
                  data_n    = color_bit(led_mask, intensity, '0, '0);
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
               if (refresh) pending_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state      <= IDLE;
         led_idx    <= '0;
         bit_idx    <= '0;
         cnt        <= '0;
         mask_sh    <= '0;
         int_sh     <= '0;
         pending    <= 1'b0;
         bit_valid  <= 1'b0;
         bit_data   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         led_idx    <= led_idx_n;
         bit_idx    <= bit_idx_n;
         cnt        <= cnt_n;
         mask_sh    <= mask_sh_n;
         int_sh     <= int_sh_n;
         pending    <= pending_n;
         bit_valid  <= valid_n;
         bit_data   <= data_n;
         busy       <= busy_n;
         frame_done <= done_n;
      end
   end
endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Randomized scoreboard bench: stimulus pushes expected frame bits, a negedge
// monitor pops them on every transfer and checks latch timing and hold rules.
module tb_ws2812b_frame_sequencer;
   localparam int NL  = 12;
   localparam int LAT = 2000;
   localparam int FB  = NL * 24;

   logic clk = 0, res_n = 0, refresh = 0, bit_ready = 1;
   logic [NL-1:0] led_mask = '0;
   logic [7:0] intensity = '0;
   logic bit_valid, bit_data, busy, frame_done;

   logic refresh2 = 0, ready2 = 1;
   logic [NL-1:0] mask2 = '0;
   logic [7:0] int2 = '0;
   logic valid2, data2, busy2, done2;

   always #5 clk = ~clk;

   ws2812b_frame_sequencer #(.NUM_LEDS(NL), .LATCH_CYCLES(LAT), .ON_CHANNELS(3'b010)) dut (
      .clk(clk), .res_n(res_n), .refresh(refresh), .led_mask(led_mask), .intensity(intensity),
      .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready), .busy(busy),
      .frame_done(frame_done));

   ws2812b_frame_sequencer #(.NUM_LEDS(NL), .LATCH_CYCLES(5), .ON_CHANNELS(3'b111)) dut2 (
      .clk(clk), .res_n(res_n), .refresh(refresh2), .led_mask(mask2), .intensity(int2),
      .bit_valid(valid2), .bit_data(data2), .bit_ready(ready2), .busy(busy2),
      .frame_done(done2));

   int n_tests = 0, n_fail = 0;
   logic q[$], q2[$];
   int xf = 0, lat = 0, lat_bad = 0, done_cnt = 0;
   bit in_latch = 0, prev_stall = 0, prev_data = 0, bp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: bit (led*24 + b) in transmit order, from the GRB/MSB-first rules.
   function automatic logic [FB-1:0] model(input logic [NL-1:0] m, input logic [7:0] in,
                                           input logic [2:0] on);
      logic [FB-1:0] f;
      for (int led = 0; led < NL; led++)
         for (int b = 0; b < 24; b++)
            f[led*24 + b] = m[led] & on[2 - b/8] & in[7 - b%8];
      return f;
   endfunction

   task automatic push1(input logic [NL-1:0] m, input logic [7:0] in);
      logic [FB-1:0] f;
      f = model(m, in, 3'b010);
      for (int i = 0; i < FB; i++) q.push_back(f[i]);
   endtask

   always @(posedge clk) begin
      #1;
      bit_ready = bp ? 1'($urandom) : 1'b1;
   end

   always @(negedge clk) begin
      if (!res_n) begin
         xf = 0; in_latch = 0; prev_stall = 0;
      end else begin
         if (in_latch) begin
            if (frame_done) begin
               check("latch_len", lat, LAT);
               check("latch_valid_low", lat_bad, 0);
               check("restart_at_done", bit_valid, q.size() != 0);
               check("busy_at_done", busy, q.size() != 0);
               in_latch = 0;
            end else begin
               lat++;
               if (bit_valid) lat_bad++;
            end
         end else if (frame_done) check("spurious_done", 1, 0);
         if (bit_valid && prev_stall) check("hold_stable", bit_data, prev_data);
         prev_stall = bit_valid && !bit_ready;
         prev_data  = bit_data;
         if (bit_valid && bit_ready) begin
            if (q.size() == 0) check("unexpected_bit", 1, 0);
            else check($sformatf("bit%0d", xf % FB), bit_data, q.pop_front());
            xf++;
            if (xf % FB == 0) begin in_latch = 1; lat = 0; lat_bad = 0; end
         end
         if (frame_done) done_cnt++;
      end
   end

   always @(negedge clk) begin
      if (res_n && valid2) begin
         if (q2.size() == 0) check("unexpected_bit2", 1, 0);
         else check("all_ch_bit", data2, q2.pop_front());
      end
   end

   task automatic issue_frame(input logic [NL-1:0] m, input logic [7:0] in);
      @(posedge clk); #1;
      led_mask = m; intensity = in; refresh = 1;
      push1(m, in);
      @(posedge clk); #1;
      refresh = 0;
      @(negedge clk);
      check("start_valid", bit_valid, 1);
      check("start_busy", busy, 1);
   endtask

   task automatic wait_idle(input int max);
      int i;
      for (i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy && q.size() == 0 && !in_latch) break;
      end
      check("idle_timeout", i < max, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int d0;
      logic [NL-1:0] m;
      logic [7:0] in;
      repeat (3) @(posedge clk); #1;
      check("rst_valid", bit_valid, 0);
      check("rst_data", bit_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      res_n = 1;

      // single lit LED, red channel only
      d0 = done_cnt;
      issue_frame(12'h001, 8'h20);
      wait_idle(4000);
      check("done_count_1", done_cnt - d0, 1);
      check("busy_after_1", busy, 0);

      // random frames
      for (int k = 0; k < 2; k++) begin
         d0 = done_cnt;
         issue_frame(NL'($urandom), 8'($urandom));
         wait_idle(4000);
         check("done_count_rand", done_cnt - d0, 1);
      end

      // random backpressure
      bp = 1;
      d0 = done_cnt;
      issue_frame(12'h5A5, 8'h08);
      wait_idle(8000);
      bp = 0;
      check("done_count_bp", done_cnt - d0, 1);

      // merged refreshes during SEND, mask changed during LATCH
      d0 = done_cnt;
      issue_frame(NL'($urandom), 8'($urandom));
      for (int k = 0; k < 3; k++) begin
         repeat (30) @(posedge clk); #1;
         refresh = 1;
         @(posedge clk); #1;
         refresh = 0;
      end
      for (int i = 0; i < 1000 && !in_latch; i++) @(negedge clk);
      check("reach_latch", in_latch, 1);
      in = 8'($urandom) | 8'h01;
      led_mask = 12'h800; intensity = in;
      push1(12'h800, in);
      wait_idle(8000);
      check("done_count_merge", done_cnt - d0, 2);
      check("busy_after_merge", busy, 0);

      // reset mid-frame
      issue_frame(12'hFFF, 8'($urandom));
      for (int i = 0; i < 2000 && xf < 100; i++) @(negedge clk);
      check("reach_xfer100", xf >= 100, 1);
      #1 res_n = 0;
      #1;
      check("midrst_valid", bit_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", frame_done, 0);
      q.delete();
      repeat (3) @(posedge clk); #1;
      res_n = 1;
      d0 = done_cnt;
      repeat (LAT + 400) @(negedge clk);
      check("no_done_after_rst", done_cnt - d0, 0);
      check("idle_after_rst", busy, 0);
      m = NL'($urandom) | 12'h001;
      issue_frame(m, 8'($urandom));
      wait_idle(4000);
      check("done_count_fresh", done_cnt - d0, 1);

      // inputs toggling while the frame is in flight
      d0 = done_cnt;
      issue_frame(NL'($urandom), 8'($urandom));
      for (int i = 0; i < FB; i++) begin
         @(posedge clk); #1;
         led_mask = NL'($urandom); intensity = 8'($urandom);
      end
      wait_idle(4000);
      check("done_count_toggle", done_cnt - d0, 1);

      // all channels enabled: 0x01 in every byte
      begin
         logic [FB-1:0] f;
         int i;
         f = model(12'hFFF, 8'h01, 3'b111);
         for (int j = 0; j < FB; j++) q2.push_back(f[j]);
         @(posedge clk); #1;
         mask2 = 12'hFFF; int2 = 8'h01; refresh2 = 1;
         @(posedge clk); #1;
         refresh2 = 0;
         for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q2.size() == 0 && !busy2) break;
         end
         check("all_ch_timeout", i < 2000, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
